// File: rtl/prog_loader_if.sv
// Byte-wide valid/ready stream carrying a program image into the loader.
interface prog_loader_if;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;

  modport master (output din, output din_valid, input din_ready);
  modport slave  (input din, input din_valid, output din_ready);
endinterface

// File: rtl/prog_loader.sv
// Writable 2^N-byte program store with a streaming loader that verifies a trailing
// additive checksum and holds the core until a verified image is present.
module prog_loader #(
  parameter int unsigned N = 2
) (
  input  logic           clk,
  input  logic           rst,
  prog_loader_if.slave   bus,
  input  logic           load_req,
  input  logic [N-1:0]   rd_addr,
  output logic [7:0]     rd_data,
  output logic           cpu_hold,
  output logic           done,
  output logic           err
);

  localparam int unsigned Depth = 1 << N;

  typedef enum logic [1:0] {StIdle, StLoad, StCheck} state_e;

  state_e       state;
  logic [N-1:0] cnt;
  logic [7:0]   sum;
  logic         ready;
  logic [7:0]   mem [Depth];

  logic hs;
  assign hs            = bus.din_valid & ready;
  assign bus.din_ready = ready;
  assign rd_data       = mem[rd_addr];

  // cpu_hold is the inverted "verified image" flag: it only clears on a good checksum
  // and is set again by the next accepted load request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= StIdle;
      cnt      <= '0;
      sum      <= '0;
      ready    <= 1'b0;
      cpu_hold <= 1'b1;
      done     <= 1'b0;
      err      <= 1'b0;
      for (int i = 0; i < Depth; i++) begin
        mem[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        StIdle: begin
          if (load_req) begin
            state    <= StLoad;
            cnt      <= '0;
            sum      <= '0;
            ready    <= 1'b1;
            cpu_hold <= 1'b1;
            err      <= 1'b0;
          end
        end
        StLoad: begin
          if (hs) begin
            mem[cnt] <= bus.din;
            sum      <= sum + bus.din;
            cnt      <= cnt + 1'b1;
            if (cnt == '1) begin
              state <= StCheck;
            end
          end
        end
        StCheck: begin
          if (hs) begin
            state <= StIdle;
            ready <= 1'b0;
            if (bus.din == sum) begin
              cpu_hold <= 1'b0;
              done     <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end
        end
        default: begin
          state <= StIdle;
          ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Randomised scoreboard bench for prog_loader: a driver streams images and queues the
// expected load outcome; a negedge monitor checks outputs against a behavioural model.
module tb_prog_loader;

  localparam int unsigned N = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         load_req;
  logic [N-1:0] rd_addr;
  logic [7:0]   rd_data;
  logic         cpu_hold;
  logic         done;
  logic         err;

  prog_loader_if bus ();

  prog_loader #(.N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .load_req (load_req),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  logic [7:0] model_mem [4];
  bit   model_ok  = 1'b0;
  bit   model_err = 1'b0;
  bit   exp_q [$];
  bit   hold_addr = 1'b0;
  bit   err_prev  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] img_sum(input logic [31:0] img);
    return 8'(img[7:0] + img[15:8] + img[23:16] + img[31:24]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) model_mem[i] = 8'h00;
    model_ok  = 1'b0;
    model_err = 1'b0;
    exp_q.delete();
  endtask

  task automatic peek(input int a, input logic [7:0] exp);
    hold_addr = 1'b1;
    rd_addr   = N'(a);
    #1;
    chk("peek rd_data", {24'h0, rd_data}, {24'h0, exp});
    hold_addr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called just after a rising edge. abort_after >= 0 pulls reset after that many bytes.
  task automatic do_load(input logic [31:0] img, input logic [7:0] cks, input bit gaps,
                         input bit mid_req, input int abort_after);
    int  i = 0;
    int  cycles = 0;
    bit  v;
    load_req = 1'b1;
    @(posedge clk);
    model_ok  = 1'b0;
    model_err = 1'b0;
    #1;
    load_req = 1'b0;
    chk("hold after load_req", {31'h0, cpu_hold}, 32'h1);
    chk("err cleared on start", {31'h0, err}, 32'h0);
    while (i < 5) begin
      if (i == abort_after) begin
        rst = 1'b0;
        bus.din_valid = 1'b0;
        #1;
        model_reset();
        chk("abort din_ready", {31'h0, bus.din_ready}, 32'h0);
        chk("abort cpu_hold", {31'h0, cpu_hold}, 32'h1);
        for (int a = 0; a < 4; a++) peek(a, 8'h00);
        @(posedge clk);
        #1;
        rst = 1'b1;
        return;
      end
      if (cycles > 100) begin
        n_cmp++;
        n_bad++;
        $display("FAIL load timeout: got %0d bytes expected 5", i);
        bus.din_valid = 1'b0;
        return;
      end
      v = gaps ? 1'($urandom % 2) : 1'b1;
      bus.din_valid = v;
      bus.din = v ? ((i < 4) ? img[8*i +: 8] : cks) : 8'($urandom);
      if (mid_req && i == 2) load_req = 1'b1;
      chk("din_ready in load", {31'h0, bus.din_ready}, 32'h1);
      @(posedge clk);
      if (v) begin
        if (i < 4) begin
          model_mem[i] = img[8*i +: 8];
        end else begin
          exp_q.push_back(cks == img_sum(img));
          model_ok  = (cks == img_sum(img));
          model_err = !model_ok;
        end
        i++;
      end
      cycles++;
      #1;
      load_req = 1'b0;
    end
    bus.din_valid = 1'b0;
    chk("din_ready after load", {31'h0, bus.din_ready}, 32'h0);
  endtask

  // Random fetch addresses, paused while the main flow probes specific addresses.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (!hold_addr) rd_addr = N'($urandom);
    end
  end

  // Monitor: outcome events against the queue, steady outputs against the model.
  initial begin
    bit exp_good;
    forever begin
      @(negedge clk);
      if (!rst) begin
        err_prev = 1'b0;
      end else begin
        if (done || (err && !err_prev)) begin
          if (exp_q.size() == 0) begin
            chk("unexpected done/err", {30'h0, done, err}, 32'h0);
          end else begin
            exp_good = exp_q.pop_front();
            chk("load outcome", {30'h0, done, err}, exp_good ? 32'h2 : 32'h1);
          end
        end
        chk("cpu_hold", {31'h0, cpu_hold}, {31'h0, !model_ok});
        chk("err level", {31'h0, err}, {31'h0, model_err});
        chk("rd_data", {24'h0, rd_data}, {24'h0, model_mem[rd_addr]});
        err_prev = err;
      end
    end
  end

  initial begin
    logic [31:0] img;
    logic [7:0]  cks;
    bit          good;
    rst = 1'b0;
    load_req = 1'b0;
    bus.din = 8'h00;
    bus.din_valid = 1'b0;
    rd_addr = '0;
    model_reset();
    idle(2);
    chk("reset din_ready", {31'h0, bus.din_ready}, 32'h0);
    chk("reset cpu_hold", {31'h0, cpu_hold}, 32'h1);
    chk("reset done", {31'h0, done}, 32'h0);
    chk("reset err", {31'h0, err}, 32'h0);
    for (int a = 0; a < 4; a++) peek(a, 8'h00);
    rst = 1'b1;
    idle(2);

    do_load(32'h78563412, 8'h14, 1'b0, 1'b0, -1);
    idle(2);
    peek(2, 8'h56);
    peek(3, 8'h78);

    do_load(32'h78563412, 8'h15, 1'b0, 1'b0, -1);
    idle(2);
    peek(0, 8'h12);

    do_load(32'hFFFFFFFF, 8'hFC, 1'b1, 1'b0, -1);
    idle(3);

    do_load($urandom, 8'h00, 1'b0, 1'b0, 2);
    idle(2);
    img = $urandom;
    do_load(img, img_sum(img), 1'b1, 1'b0, -1);
    idle(2);

    do_load(32'h04030201, 8'h0A, 1'b0, 1'b1, -1);
    idle(2);
    peek(0, 8'h01);
    peek(3, 8'h04);

    for (int t = 0; t < 8; t++) begin
      img  = $urandom;
      good = 1'($urandom % 2);
      cks  = good ? img_sum(img) : 8'(img_sum(img) + 8'($urandom_range(1, 255)));
      do_load(img, cks, 1'b1, 1'($urandom % 2), -1);
      idle($urandom_range(1, 3));
    end

    idle(3);
    chk("outcomes pending", exp_q.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Writable program store and its loader for the microprocessor. It accepts a program image over a byte-wide valid/ready stream and writes it into a 2^N-byte program memory. It verifies a trailing 8-bit additive checksum, then releases the core from hold. Its combinational read port replaces the fixed program ROM: the program counter address drives `rd_addr`, and `rd_data` feeds the instruction bus.

## Interface
Parameters:
- `N`, default 2: program address width; memory depth is 2^N bytes (matches program counter width).

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `load_req`  in  1  start a load; sampled only in IDLE.
- `din`  in  8  image byte.
- `din_valid`  in  1  `din` holds a valid byte.
- `din_ready`  out  1  loader accepts a byte this cycle.
- `rd_addr`  in  N  fetch address from the program counter.
- `rd_data`  out  8  instruction byte at `rd_addr`, combinational.
- `cpu_hold`  out  1  hold request to the core's reset/stall path.
- `done`  out  1  one-cycle pulse on a successful load.
- `err`  out  1  checksum mismatch flag; sticky until the next load starts.

## Operation
- The program image is 2^N program bytes in address order, followed by one checksum byte. The checksum equals the sum of the program bytes mod 256.
- A handshake occurs on any rising edge where `din_valid` and `din_ready` are both 1.
- States:
  - IDLE: `din_ready`=0. If `load_req`=1, go to LOAD, clear `cnt`, `sum`, `ok` and `err`.
  - LOAD: `din_ready`=1. On each handshake:
    - write `mem[cnt] <= din`;
    - update `sum <= sum + din` (8-bit, wraps);
    - increment `cnt`.
    - After the handshake at `cnt` = 2^N-1, go to CHECK. `cnt` wraps to 0 and is not used further.
  - CHECK: `din_ready`=1. On a handshake:
    - if `din == sum`, set `ok`=1 and pulse `done`;
    - otherwise set `err`=1.
    - In both cases go to IDLE.
- `cpu_hold` = 1 unless the state is IDLE and `ok`=1. The core only runs from a verified image.
- `rd_data` = `mem[rd_addr]` at all times, including during a load. The core is held during a load, so partial images are never executed.
- A failed load leaves the partially written image in memory, with `ok`=0 and `cpu_hold`=1. Recovery is a new `load_req`.
- `load_req` in LOAD or CHECK is ignored. It does not restart the load.
- `load_req` in IDLE with `ok`=1 starts a reload. `cpu_hold` rises on the next edge.
- There is no timeout. Gaps in `din_valid` stall the loader indefinitely.

## Timing
- Reset (`rst`=0, asynchronous) produces:
  - state IDLE;
  - all memory bytes 0x00, so `rd_data` = 0x00;
  - `cnt`=0, `sum`=0x00, `ok`=0;
  - outputs `din_ready`=0, `cpu_hold`=1, `done`=0, `err`=0.
- Reset asserted mid-load aborts the load immediately. Already-written bytes are cleared to 0x00.
- `load_req` sampled at edge k means state is LOAD after edge k, so `din_ready`=1 from cycle k+1.
- A byte written at edge k is visible on `rd_data` for a matching `rd_addr` in cycle k+1.
- With `din_valid` held high, the minimum load is 1 IDLE cycle plus 2^N+1 handshake cycles.
- `done` and `err` are registered. Each asserts in the cycle after the checksum handshake. `done` is high for exactly 1 cycle.
- `cpu_hold` falls in the same cycle that `done` rises.
- `err` stays high until the edge that accepts the next `load_req`.

## Test plan
- **Good load (N=2):** pulse `load_req`, then stream 0x12, 0x34, 0x56, 0x78 followed by checksum 0x14.
  - One-cycle `done` pulse, `err`=0, `cpu_hold` falls to 0.
  - `rd_addr`=2 gives `rd_data`=0x56; `rd_addr`=3 gives 0x78.
- **Bad checksum:** same bytes, then checksum 0x15.
  - `err`=1, no `done` pulse, `cpu_hold` stays 1.
  - `rd_addr`=0 gives 0x12.
  - A following `load_req` clears `err` on its accepting edge.
- **Backpressure/gaps:** toggle `din_valid` randomly with a good image (e.g. 0xFF ×4, checksum 0xFC to exercise sum wrap).
  - Only handshaked bytes are written; `done` fires once.
- **Reset mid-load:** assert `rst`=0 after 2 bytes.
  - Immediately: `din_ready`=0, `cpu_hold`=1, `rd_data`=0x00 at all addresses.
  - A fresh full load then succeeds.
- **Reload and ignored request:**
  - After a good load, pulse `load_req`: `cpu_hold` rises next cycle.
  - A second `load_req` mid-load does not reset `cnt`.
  - A second image 0x01, 0x02, 0x03, 0x04 with checksum 0x0A loads correctly.
